uart_tx_sched: RTL and testbench

Transmit scheduler that shares one `UART_TX` serializer among `NUM_REQ` byte producers in the v65C02 computer (CPU UART register port, debug monitor, etc.). It holds one byte per requester, grants the serializer round-robin, and sequences the `we_i`/`busy_o` handshake of `UART_TX`. It also generates the 16x-oversample baud strobe (`brg_stb_i`) that feeds `UART_TX`.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_brg.sv | 43 ++++
 rtl/uart_tx_sched.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART scheduler definitions: FSM state encoding, busy-handshake
// timeout and the default baud-strobe divider.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

  // Cycles WAIT_BUSY waits for the serializer to raise busy before giving up.
  localparam int unsigned UART_BUSY_TIMEOUT = 2;

  // System clocks per 16x-oversample baud strobe.
  localparam int unsigned UART_BRG_DIV_DEFAULT = 4;

endpackage

// File: rtl/uart_brg.sv
// Free-running baud strobe generator: counts 0..BRG_DIV-1 and pulses stb_o
// while the counter sits at BRG_DIV-1.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset (counter and strobe to 0)
//   stb_o  registered one-cycle strobe every BRG_DIV clocks
module uart_brg
  import uart_pkg::*;
#(
  parameter int unsigned BRG_DIV = UART_BRG_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic stb_o
);

  localparam int unsigned CNT_W = (BRG_DIV > 2) ? $clog2(BRG_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BRG_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // Wrap-around counter next value.
  always_comb begin
    cnt_n = cnt + CNT_W'(1);
    if (cnt == CNT_LAST) begin
      cnt_n = '0;
    end
  end

  // Strobe is registered from the next count so it is high in the cycle the
  // counter equals CNT_LAST.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      stb_o <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      stb_o <= (cnt_n == CNT_LAST);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART_TX serializer among NUM_REQ byte producers. Each requester
// owns a one-byte holding register; the serializer is granted round-robin and
// the we/busy handshake of UART_TX is sequenced by a four-state FSM.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   stb_i, din_i   per-requester write strobe and byte (req k: din_i[8k+7:8k])
//   full_o         holding register k occupied
//   ovr_o          one-cycle pulse when a strobe hits a full register
//   grant_o        one-hot owner of the current or most recent transfer
//   idle_o         FSM idle and all holding registers empty
//   tx_we_o, tx_din_o, tx_busy_i   UART_TX handshake
//   brg_stb_o      16x-oversample baud strobe for UART_TX
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned BRG_DIV = UART_BRG_DIV_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   stb_i,
  input  logic [8*NUM_REQ-1:0] din_i,
  output logic [NUM_REQ-1:0]   full_o,
  output logic [NUM_REQ-1:0]   ovr_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 idle_o,
  output logic                 tx_we_o,
  output logic [7:0]           tx_din_o,
  input  logic                 tx_busy_i,
  output logic                 brg_stb_o
);

  localparam int unsigned RR_W = $clog2(NUM_REQ);
  localparam int unsigned TO_W = (UART_BUSY_TIMEOUT > 2) ? $clog2(UART_BUSY_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(UART_BUSY_TIMEOUT - 1);

  tx_state_t          state, state_n;
  logic [RR_W-1:0]    rr, rr_n;
  logic [TO_W-1:0]    tmo_cnt, tmo_n;
  logic [7:0]         hold [NUM_REQ];
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] full_n, ovr_n, grant_n;
  logic               idle_n, tx_we_n;
  logic [7:0]         tx_din_n;
  logic [RR_W-1:0]    pick_idx;
  logic               pick_vld;

  // Baud strobe runs independently of the scheduler.
  uart_brg #(
    .BRG_DIV (BRG_DIV)
  ) u_brg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .stb_o (brg_stb_o)
  );

  // Round-robin pick: first occupied register searching upward from rr.
  always_comb begin
    int unsigned cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_vld && full_o[RR_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = RR_W'(cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    int unsigned rr_next;
    state_n  = state;
    rr_n     = rr;
    tmo_n    = tmo_cnt;
    grant_n  = grant_o;
    tx_din_n = tx_din_o;
    tx_we_n  = 1'b0;
    rr_next  = 0;
    // A strobe on a full register (including the owner during ISSUE) is dropped.
    accept   = stb_i & ~full_o;
    ovr_n    = stb_i & full_o;
    full_n   = full_o | accept;

    case (state)
      ST_IDLE: begin
        // Serializer has no reset, so wait until it is quiet before issuing.
        if (pick_vld && !tx_busy_i) begin
          state_n  = ST_ISSUE;
          grant_n  = NUM_REQ'(1) << pick_idx;
          tx_din_n = hold[pick_idx];
          tx_we_n  = 1'b1;
          rr_next  = 32'(pick_idx) + 1;
          if (rr_next >= NUM_REQ) begin
            rr_next = 0;
          end
          rr_n = RR_W'(rr_next);
        end
      end
      ST_ISSUE: begin
        full_n  = full_n & ~grant_o;
        tmo_n   = '0;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A serializer that never raises busy is treated as having sent the byte.
        if (tx_busy_i) begin
          state_n = ST_WAIT_DONE;
        end else if (tmo_cnt == TO_LAST) begin
          state_n = ST_IDLE;
        end else begin
          tmo_n = tmo_cnt + TO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    idle_n = (state_n == ST_IDLE) && !(|full_n);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      rr       <= '0;
      tmo_cnt  <= '0;
      full_o   <= '0;
      ovr_o    <= '0;
      grant_o  <= '0;
      idle_o   <= 1'b0;
      tx_we_o  <= 1'b0;
      tx_din_o <= '0;
    end else begin
      state    <= state_n;
      rr       <= rr_n;
      tmo_cnt  <= tmo_n;
      full_o   <= full_n;
      ovr_o    <= ovr_n;
      grant_o  <= grant_n;
      idle_o   <= idle_n;
      tx_we_o  <= tx_we_n;
      tx_din_o <= tx_din_n;
    end
  end

  // Holding data; occupancy is tracked by full_o, so the data needs no reset.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (accept[k]) begin
        hold[k] <= din_i[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural serializer model and a
// scoreboard of expected (byte, grant) pairs popped on every tx_we pulse.
module tb_uart_tx_sched;

  localparam int unsigned NUM_REQ  = 2;
  localparam int unsigned BRG_DIV  = 4;
  localparam int          BUSY_LEN = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  stb = 2'b00;
  logic [15:0] din = 16'h0000;
  logic [1:0]  full, ovr, grant;
  logic        idle, tx_we, tx_busy, brg_stb;
  logic [7:0]  tx_din;

  typedef struct {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   model_en = 1'b1;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NUM_REQ (NUM_REQ),
    .BRG_DIV (BRG_DIV)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .stb_i     (stb),
    .din_i     (din),
    .full_o    (full),
    .ovr_o     (ovr),
    .grant_o   (grant),
    .idle_o    (idle),
    .tx_we_o   (tx_we),
    .tx_din_o  (tx_din),
    .tx_busy_i (tx_busy),
    .brg_stb_o (brg_stb)
  );

  // Serializer model: busy rises the cycle after we and lasts BUSY_LEN cycles.
  // With model_en cleared it behaves as a stub that never raises busy.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (model_en && tx_we === 1'b1) busy_cnt <= BUSY_LEN;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every issued byte must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (tx_we === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed tx_din=%0h expected no transfer", tx_din);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_data", 32'(tx_din), 32'(e.data));
        chk("sb_grant", 32'(grant), 32'(e.grant));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(idle === 1'b1 && tx_busy === 1'b0) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(idle === 1'b1 && tx_busy === 1'b0), 32'd1);
  endtask

  task automatic wait_busy(input logic lvl, input string tag);
    int n;
    n = 0;
    while (tx_busy !== lvl && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(tx_busy), 32'(lvl));
  endtask

  task automatic send1(input int k, input logic [7:0] d);
    stb      = 2'(1 << k);
    din      = (k == 0) ? {8'h00, d} : {d, 8'h00};
    push(d, 2'(1 << k));
    tick();
    stb = 2'b00;
    wait_idle("send1_idle");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_ovr"}, 32'(ovr), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
    chk({tag, "_idle"}, 32'(idle), 32'd0);
    chk({tag, "_we"}, 32'(tx_we), 32'd0);
    chk({tag, "_din"}, 32'(tx_din), 32'd0);
    chk({tag, "_brg"}, 32'(brg_stb), 32'd0);
  endtask

  // Baud phase after reset release: strobe in the third cycle only.
  task automatic chk_brg_phase(input string tag);
    tick();
    chk({tag, "_idle1"}, 32'(idle), 32'd1);
    chk({tag, "_brg1"}, 32'(brg_stb), 32'd0);
    tick();
    chk({tag, "_brg2"}, 32'(brg_stb), 32'd0);
    tick();
    chk({tag, "_brg3"}, 32'(brg_stb), 32'd1);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    rst = 1'b0;
    chk_brg_phase("rel");
    tick();
    chk("rel_brg4", 32'(brg_stb), 32'd0);

    // Single byte on requester 0: full in cycle 1, we in cycle 2, clear in 3
    stb = 2'b01;
    din = 16'h0075;
    push(8'h75, 2'b01);
    tick();
    stb = 2'b00;
    chk("single_full1", 32'(full), 32'h1);
    chk("single_we1", 32'(tx_we), 32'd0);
    tick();
    chk("single_we2", 32'(tx_we), 32'd1);
    chk("single_din2", 32'(tx_din), 32'h75);
    chk("single_grant2", 32'(grant), 32'h1);
    tick();
    chk("single_full3", 32'(full), 32'h0);
    chk("single_we3", 32'(tx_we), 32'd0);
    wait_idle("single_idle");
    chk("single_grant_hold", 32'(grant), 32'h1);
    chk("single_din_hold", 32'(tx_din), 32'h75);

    // Simultaneous strobes with rr=0 (after issuing requester 1)
    send1(1, 8'h3C);
    stb = 2'b11;
    din = 16'hA553;
    push(8'h53, 2'b01);
    push(8'hA5, 2'b10);
    tick();
    stb = 2'b00;
    chk("simul0_full", 32'(full), 32'h3);
    wait_idle("simul0_idle");

    // Simultaneous strobes with rr=1 (after issuing requester 0)
    send1(0, 8'h0F);
    stb = 2'b11;
    din = 16'hA553;
    push(8'hA5, 2'b10);
    push(8'h53, 2'b01);
    tick();
    stb = 2'b00;
    wait_idle("simul1_idle");

    // Overrun: second strobe while 0x11 is held is dropped
    stb = 2'b10;
    din = 16'h1100;
    push(8'h11, 2'b10);
    tick();
    din = 16'h2200;
    chk("ovr_full1", 32'(full), 32'h2);
    tick();
    stb = 2'b00;
    chk("ovr_pulse", 32'(ovr), 32'h2);
    chk("ovr_we", 32'(tx_we), 32'd1);
    tick();
    chk("ovr_clear", 32'(ovr), 32'h0);
    wait_idle("ovr_idle");
    chk("ovr_sb_empty", 32'(sb.size()), 32'd0);

    // Strobe from the owner during ISSUE is dropped
    stb = 2'b01;
    din = 16'h0081;
    push(8'h81, 2'b01);
    tick();
    stb = 2'b00;
    tick();
    stb = 2'b01;
    din = 16'h0082;
    tick();
    stb = 2'b00;
    chk("issue_ovr", 32'(ovr), 32'h1);
    chk("issue_full", 32'(full), 32'h0);
    wait_idle("issue_idle");

    // Refill during WAIT_DONE; next ISSUE two cycles after busy falls
    stb = 2'b01;
    din = 16'h005A;
    push(8'h5A, 2'b01);
    tick();
    stb = 2'b00;
    wait_busy(1'b1, "refill_busy_hi");
    tick();
    stb = 2'b01;
    din = 16'h006B;
    push(8'h6B, 2'b01);
    tick();
    stb = 2'b00;
    chk("refill_full", 32'(full), 32'h1);
    wait_busy(1'b0, "refill_busy_lo");
    chk("refill_we_t0", 32'(tx_we), 32'd0);
    tick();
    chk("refill_we_t1", 32'(tx_we), 32'd0);
    tick();
    chk("refill_we_t2", 32'(tx_we), 32'd1);
    chk("refill_din_t2", 32'(tx_din), 32'h6B);
    wait_idle("refill_idle");

    // Busy timeout with a stub serializer
    model_en = 1'b0;
    stb = 2'b10;
    din = 16'h4400;
    push(8'h44, 2'b10);
    tick();
    stb = 2'b00;
    tick();
    chk("tmo_we", 32'(tx_we), 32'd1);
    tick();
    chk("tmo_full", 32'(full), 32'h0);
    chk("tmo_idle_wb1", 32'(idle), 32'd0);
    tick();
    chk("tmo_idle_wb2", 32'(idle), 32'd0);
    tick();
    chk("tmo_idle_back", 32'(idle), 32'd1);
    chk("tmo_we_low", 32'(tx_we), 32'd0);
    model_en = 1'b1;

    // Reset mid-frame with requester 1 full
    stb = 2'b01;
    din = 16'h0077;
    push(8'h77, 2'b01);
    tick();
    stb = 2'b00;
    wait_busy(1'b1, "rst_busy_hi");
    tick();
    stb = 2'b10;
    din = 16'h1200;
    tick();
    stb = 2'b00;
    chk("rst_pre_full", 32'(full), 32'h2);
    rst = 1'b1;
    tick();
    chk_zero("rst_mid");
    rst = 1'b0;
    chk_brg_phase("rst_rel");
    stb = 2'b01;
    din = 16'h0099;
    push(8'h99, 2'b01);
    tick();
    stb = 2'b00;
    for (int n = 0; n < 100 && tx_busy === 1'b1; n++) begin
      chk("rst_no_we", 32'(tx_we), 32'd0);
      tick();
    end
    wait_idle("rst_idle");
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before timeout");
    $fatal(1, "watchdog");
  end

endmodule
